// File: rtl/udp_tx_packer_pkg.sv
// udp_tx_packer_pkg: shared definitions for the UDP transmit packer.
//   - rd_state_e    : one-hot read-side FSM encoding
//   - MinPktWords   : smallest legal payload (5 words = the framer's 18-byte minimum, rounded up)
//   - MaxPktWords   : largest supported payload
//   - calc_byte_num : payload length in 16-bit halfwords as reported to the framer
package udp_tx_packer_pkg;

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StStart = 4'b0010,
        StSend  = 4'b0100,
        StGap   = 4'b1000
    } rd_state_e;

    localparam int unsigned MinPktWords = 5;
    localparam int unsigned MaxPktWords = 1024;

    // The framer counts the payload in halfwords; each buffered word is two of them.
    function automatic logic [15:0] calc_byte_num(input int unsigned pkt_words);
        return 16'(pkt_words * 2);
    endfunction

endpackage

// File: rtl/udp_tx_packer_ram_sdp.sv
// pp_ram_sdp: simple dual-port RAM, one write port and one read port, same clock.
// Read data is registered (1-clock latency); no reset on the array or read register.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address, sampled every clock
//   rdata_o : read data, valid the clock after raddr_i is presented
module pp_ram_sdp #(
    parameter int unsigned Width = 32,
    parameter int unsigned AddrW = 9
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << AddrW;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/udp_tx_packer.sv
// udp_tx_packer: packs an 8-bit sample stream into big-endian 32-bit words held in a two-bank
// ping-pong buffer and hands each full bank to the UDP/IP transmit framer.
// PKT_WORDS must lie in MinPktWords..MaxPktWords; START_LEN >= 1.
//   clk           : system clock (shared with the framer)
//   rst_n         : asynchronous active-low reset
//   din_i         : sample byte
//   din_vld_i     : din_i valid
//   din_rdy_o     : byte accepted when din_vld_i && din_rdy_o
//   tx_start_en_o : frame start level to the framer, high START_LEN clocks
//   tx_byte_num_o : payload length in halfwords (2*PKT_WORDS), constant
//   tx_req_i      : single-cycle word request from the framer
//   tx_data_o     : show-ahead payload word for the next request
//   tx_done_i     : single-cycle frame-complete pulse
//   overflow_o    : sticky, set when a byte is dropped
//   frame_cnt_o   : frames started, wrapping
module udp_tx_packer
    import udp_tx_packer_pkg::*;
#(
    parameter int unsigned PKT_WORDS  = 256,
    parameter int unsigned GAP_CYCLES = 12,
    parameter int unsigned START_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din_i,
    input  logic        din_vld_i,
    output logic        din_rdy_o,
    output logic        tx_start_en_o,
    output logic [15:0] tx_byte_num_o,
    input  logic        tx_req_i,
    output logic [31:0] tx_data_o,
    input  logic        tx_done_i,
    output logic        overflow_o,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned OffW  = $clog2(PKT_WORDS);
    localparam int unsigned AddrW = OffW + 1;

    localparam logic [OffW-1:0] LastOff   = OffW'(PKT_WORDS - 1);
    localparam logic [15:0]     StartLast = 16'(START_LEN - 1);
    // The IDLE hand-off cycle is part of the inter-frame gap, so GAP itself lasts one clock less.
    localparam logic [15:0]     GapLast   = 16'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);

    // ---------------------------------------------------------------------------------------
    // Write side
    // ---------------------------------------------------------------------------------------
    logic [1:0]      byte_cnt_q;
    logic [23:0]     acc_q;
    logic            wr_bank_q;
    logic [OffW-1:0] wr_addr_q;
    logic [1:0]      full_q, full_d;
    logic [1:0]      full_seen_q;
    logic            overflow_q;

    logic            accept;
    logic            word_wr;
    logic            wr_last;
    logic [31:0]     wr_word;

    // Read side signals used by the bank flags
    rd_state_e       state_q;
    logic            rd_bank_q, rd_bank_d;
    logic [OffW-1:0] rd_addr_q, rd_addr_d;
    logic            rd_advance;
    logic            gap_done;
    logic [15:0]     gap_cnt_q;

    assign din_rdy_o = ~full_q[wr_bank_q];
    assign accept    = din_vld_i & din_rdy_o;
    assign word_wr   = accept & (byte_cnt_q == 2'd3);
    assign wr_last   = (wr_addr_q == LastOff);
    assign wr_word   = {acc_q, din_i};

    // Writer sets and reader clears always address different banks, so both may act at once.
    always_comb begin
        full_d = full_q;
        if (word_wr && wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (gap_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q  <= 2'd0;
            acc_q       <= 24'd0;
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            full_q      <= 2'b00;
            full_seen_q <= 2'b00;
            overflow_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            full_seen_q <= full_q;
            if (din_vld_i && !din_rdy_o) begin
                overflow_q <= 1'b1;
            end
            if (accept) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                acc_q      <= {acc_q[15:0], din_i};
            end
            if (word_wr) begin
                if (wr_last) begin
                    wr_addr_q <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_addr_q <= wr_addr_q + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Buffer RAM, address {bank, offset}
    // ---------------------------------------------------------------------------------------
    logic [31:0] rdata;

    // The read address follows next-state values so the RAM already holds the new word one
    // clock after a request or a bank switch.
    pp_ram_sdp #(
        .Width (32),
        .AddrW (AddrW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (word_wr),
        .waddr_i ({wr_bank_q, wr_addr_q}),
        .wdata_i (wr_word),
        .raddr_i ({rd_bank_d, rd_addr_d}),
        .rdata_o (rdata)
    );

    // ---------------------------------------------------------------------------------------
    // Read side
    // ---------------------------------------------------------------------------------------
    logic        tx_start_en_q;
    logic [31:0] tx_data_q;
    logic [15:0] frame_cnt_q;
    logic [15:0] start_cnt_q;
    logic        ld_q;

    // A request together with tx_done is not served; the frame is over.
    assign rd_advance = (state_q == StSend) && tx_req_i && !tx_done_i && (rd_addr_q != LastOff);
    assign gap_done   = (state_q == StGap) && (gap_cnt_q == GapLast);

    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        if (rd_advance) begin
            rd_addr_d = rd_addr_q + 1'b1;
        end
        if (gap_done) begin
            rd_addr_d = '0;
            rd_bank_d = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rd_bank_q     <= 1'b0;
            rd_addr_q     <= '0;
            tx_start_en_q <= 1'b0;
            tx_data_q     <= 32'd0;
            frame_cnt_q   <= 16'd0;
            start_cnt_q   <= 16'd0;
            gap_cnt_q     <= 16'd0;
            ld_q          <= 1'b0;
        end else begin
            rd_bank_q <= rd_bank_d;
            rd_addr_q <= rd_addr_d;
            ld_q      <= rd_advance;
            if (ld_q) begin
                tx_data_q <= rdata;
            end
            unique case (state_q)
                StIdle: begin
                    // full_seen_q delays a fresh full flag by one clock so the RAM read of
                    // word 0 is settled before the frame starts.
                    if (full_q[rd_bank_q] && full_seen_q[rd_bank_q]) begin
                        state_q       <= StStart;
                        tx_start_en_q <= 1'b1;
                        tx_data_q     <= rdata;
                        frame_cnt_q   <= frame_cnt_q + 16'd1;
                        start_cnt_q   <= 16'd0;
                    end
                end
                StStart: begin
                    if (start_cnt_q == StartLast) begin
                        state_q       <= StSend;
                        tx_start_en_q <= 1'b0;
                    end else begin
                        start_cnt_q <= start_cnt_q + 16'd1;
                    end
                end
                StSend: begin
                    if (tx_done_i) begin
                        state_q   <= StGap;
                        gap_cnt_q <= 16'd0;
                    end
                end
                StGap: begin
                    if (gap_done) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    tx_start_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_start_en_o = tx_start_en_q;
    assign tx_byte_num_o = calc_byte_num(PKT_WORDS);
    assign tx_data_o     = tx_data_q;
    assign overflow_o    = overflow_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_udp_tx_packer.sv
// tb_udp_tx_packer: directed self-checking bench for udp_tx_packer with PKT_WORDS=5,
// GAP_CYCLES=12, START_LEN=4.
module tb_udp_tx_packer;

    localparam int unsigned PktWords  = 5;
    localparam int unsigned GapCycles = 12;
    localparam int unsigned StartLen  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = 8'd0;
    logic        din_vld = 1'b0;
    logic        din_rdy;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req = 1'b0;
    logic [31:0] tx_data;
    logic        tx_done = 1'b0;
    logic        overflow;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    udp_tx_packer #(
        .PKT_WORDS  (PktWords),
        .GAP_CYCLES (GapCycles),
        .START_LEN  (StartLen)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din_i         (din),
        .din_vld_i     (din_vld),
        .din_rdy_o     (din_rdy),
        .tx_start_en_o (tx_start_en),
        .tx_byte_num_o (tx_byte_num),
        .tx_req_i      (tx_req),
        .tx_data_o     (tx_data),
        .tx_done_i     (tx_done),
        .overflow_o    (overflow),
        .frame_cnt_o   (frame_cnt)
    );

    // Word i of a frame whose first byte is base, packed MSB-first.
    function automatic logic [31:0] exp_word(input logic [7:0] base, input int i);
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        b0 = base + 8'(4 * i);
        b1 = b0 + 8'd1;
        b2 = b0 + 8'd2;
        b3 = b0 + 8'd3;
        return {b0, b1, b2, b3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] base);
        for (int i = 0; i < 4 * int'(PktWords); i++) begin
            din     = base + 8'(i);
            din_vld = 1'b1;
            tick();
        end
        din_vld = 1'b0;
    endtask

    // Request pulse, then two clocks for the show-ahead word to appear.
    task automatic pulse_req();
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!tx_start_en && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_start_low(output int h);
        h = 0;
        while (tx_start_en && h < 20) begin
            tick();
            h++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (din_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_din_rdy: got %b expected 1", din_rdy);
        end
        checks++;
        if (tx_start_en !== 1'b0) begin
            errors++; $display("FAIL reset_start_en: got %b expected 0", tx_start_en);
        end
        checks++;
        if (tx_data !== 32'h0) begin
            errors++; $display("FAIL reset_tx_data: got %h expected 0", tx_data);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow: got %b expected 0", overflow);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
        end
        checks++;
        if (tx_byte_num !== 16'd10) begin
            errors++; $display("FAIL reset_byte_num: got %0d expected 10", tx_byte_num);
        end
    endtask

    task automatic test_single_frame();
        int n;
        int h;
        push_frame(8'h01);
        wait_start(n);
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL start_latency: got %0d clocks expected 2", n);
        end
        wait_start_low(h);
        checks++;
        if (h != int'(StartLen)) begin
            errors++; $display("FAIL start_len: got %0d clocks expected %0d", h, StartLen);
        end
        checks++;
        if (tx_byte_num !== 16'd10) begin
            errors++; $display("FAIL byte_num: got %0d expected 10", tx_byte_num);
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++; $display("FAIL frame_cnt_1: got %0d expected 1", frame_cnt);
        end
        checks++;
        if (tx_data !== exp_word(8'h01, 0)) begin
            errors++; $display("FAIL f1_word0: got %h expected %h", tx_data, exp_word(8'h01, 0));
        end
        for (int i = 1; i < int'(PktWords); i++) begin
            pulse_req();
            checks++;
            if (tx_data !== exp_word(8'h01, i)) begin
                errors++;
                $display("FAIL f1_word%0d: got %h expected %h", i, tx_data, exp_word(8'h01, i));
            end
        end
    endtask

    task automatic test_req_past_end();
        for (int i = 0; i < 6; i++) begin
            pulse_req();
            checks++;
            if (tx_data !== 32'h11121314) begin
                errors++; $display("FAIL past_end_%0d: got %h expected 11121314", i, tx_data);
            end
        end
    endtask

    task automatic test_overflow();
        push_frame(8'h21);
        checks++;
        if (din_rdy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL both_full: got rdy=%b ovf=%b expected rdy=0 ovf=0", din_rdy, overflow);
        end
        din     = 8'hEE;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        tick();
        checks++;
        if (overflow !== 1'b1 || din_rdy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_set: got ovf=%b rdy=%b expected ovf=1 rdy=0", overflow, din_rdy);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int h;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_start(k);
        checks++;
        if (k != int'(GapCycles)) begin
            errors++; $display("FAIL gap_len: got %0d clocks expected %0d", k, GapCycles);
        end
        wait_start_low(h);
        checks++;
        if (frame_cnt !== 16'd2) begin
            errors++; $display("FAIL frame_cnt_2: got %0d expected 2", frame_cnt);
        end
        checks++;
        if (din_rdy !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL after_gap_flags: got rdy=%b ovf=%b expected rdy=1 ovf=1", din_rdy, overflow);
        end
        checks++;
        if (tx_data !== exp_word(8'h21, 0)) begin
            errors++; $display("FAIL f2_word0: got %h expected %h", tx_data, exp_word(8'h21, 0));
        end
        for (int i = 1; i < int'(PktWords); i++) begin
            pulse_req();
            checks++;
            if (tx_data !== exp_word(8'h21, i)) begin
                errors++;
                $display("FAIL f2_word%0d: got %h expected %h", i, tx_data, exp_word(8'h21, i));
            end
        end
    endtask

    task automatic test_stray();
        int n;
        int h;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        // Now in GAP
        for (int j = 0; j < 3; j++) begin
            tx_req  = 1'b1;
            tx_done = 1'b1;
            tick();
            tx_req  = 1'b0;
            tx_done = 1'b0;
            tick();
            checks++;
            if (tx_data !== 32'h31323334 || tx_start_en !== 1'b0) begin
                errors++;
                $display("FAIL gap_stray_%0d: got data=%h start=%b expected 31323334 0",
                         j, tx_data, tx_start_en);
            end
        end
        for (int j = 0; j < 20; j++) tick();
        // Now in IDLE with no full bank
        for (int j = 0; j < 3; j++) begin
            tx_req  = 1'b1;
            tx_done = 1'b1;
            tick();
            tx_req  = 1'b0;
            tx_done = 1'b0;
            tick();
        end
        checks++;
        if (tx_data !== 32'h31323334 || tx_start_en !== 1'b0 || frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL idle_stray: got data=%h start=%b cnt=%0d expected 31323334 0 2",
                     tx_data, tx_start_en, frame_cnt);
        end
        push_frame(8'h41);
        wait_start(n);
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL f3_latency: got %0d clocks expected 2", n);
        end
        wait_start_low(h);
        checks++;
        if (frame_cnt !== 16'd3 || tx_data !== 32'h41424344) begin
            errors++;
            $display("FAIL f3_start: got cnt=%0d data=%h expected 3 41424344", frame_cnt, tx_data);
        end
        pulse_req();
        checks++;
        if (tx_data !== 32'h45464748) begin
            errors++; $display("FAIL f3_word1: got %h expected 45464748", tx_data);
        end
    endtask

    task automatic test_reset_mid_send();
        int n;
        int h;
        pulse_req();
        checks++;
        if (tx_data !== 32'h494A4B4C) begin
            errors++; $display("FAIL f3_word2: got %h expected 494a4b4c", tx_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_start_en !== 1'b0 || tx_data !== 32'h0 || overflow !== 1'b0 ||
            frame_cnt !== 16'd0 || din_rdy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got start=%b data=%h ovf=%b cnt=%0d rdy=%b expected 0 0 0 0 1",
                     tx_start_en, tx_data, overflow, frame_cnt, din_rdy);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        tick();
        checks++;
        if (tx_data !== 32'h0 || tx_start_en !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_req: got data=%h start=%b expected 0 0", tx_data, tx_start_en);
        end
        push_frame(8'h61);
        wait_start(n);
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL f4_latency: got %0d clocks expected 2", n);
        end
        wait_start_low(h);
        checks++;
        if (frame_cnt !== 16'd1 || tx_data !== 32'h61626364) begin
            errors++;
            $display("FAIL f4_start: got cnt=%0d data=%h expected 1 61626364", frame_cnt, tx_data);
        end
        pulse_req();
        checks++;
        if (tx_data !== 32'h65666768) begin
            errors++; $display("FAIL f4_word1: got %h expected 65666768", tx_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_req_past_end();
        test_overflow();
        test_back_to_back();
        test_stray();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
